// File: rtl/booth_seq_mult_if.sv
// ---------------------------------------------------------------------------
// booth_seq_mult_if
// Request/result bundle for the sequential Booth multiplier.
//   start        : request a multiply (honoured only while busy is low)
//   signed_mode  : 1 = two's-complement operands, 0 = unsigned
//   input1       : multiplicand, W bits
//   input2       : multiplier, W bits
//   busy         : operation in progress
//   done         : one-cycle pulse, result valid
//   result       : 2W-bit product
//   count        : Booth steps completed in current/last operation
// master drives the request side, slave is the multiplier.
// ---------------------------------------------------------------------------
interface booth_seq_mult_if #(
    parameter int W     = 4,
    parameter int CNT_W = $clog2(W + 2)
);
    logic               start;
    logic               signed_mode;
    logic [W-1:0]       input1;
    logic [W-1:0]       input2;
    logic               busy;
    logic               done;
    logic [2*W-1:0]     result;
    logic [CNT_W-1:0]   count;

    modport master (
        output start, signed_mode, input1, input2,
        input  busy, done, result, count
    );

    modport slave (
        input  start, signed_mode, input1, input2,
        output busy, done, result, count
    );
endinterface

// File: rtl/booth_seq_mult.sv
// ---------------------------------------------------------------------------
// booth_seq_mult
// Radix-2 Booth multiplier, one step per clock, W+1 steps per operation.
// Operands are widened to W+1 bits (sign- or zero-extended) so the same
// datapath produces exact signed and unsigned products.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high; aborts any operation, clears outputs
//   bus   : booth_seq_mult_if.slave (start/signed_mode/input1/input2 in,
//           busy/done/result/count out)
// ---------------------------------------------------------------------------
module booth_seq_mult #(
    parameter int W     = 4,
    parameter int CNT_W = $clog2(W + 2)
) (
    input  logic             clk,
    input  logic             reset,
    booth_seq_mult_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                 state;
    state_t                 state_nxt;

    logic signed [W:0]      a;          // accumulator
    logic signed [W:0]      m;          // extended multiplicand
    logic        [W:0]      q;          // extended multiplier, shifts out LSB-first
    logic                   qm1;        // Q-1 bit
    logic        [2*W-1:0]  result_r;
    logic        [CNT_W-1:0] count_r;

    logic signed [W:0]      a_step;
    logic signed [W:0]      a_shf;
    logic        [W:0]      q_shf;
    logic                   accept;
    logic                   last_step;

    // Widen an operand to W+1 bits; the top bit is the sign only in signed mode.
    function automatic logic signed [W:0] extend(input logic [W-1:0] v,
                                                 input logic         sm);
        return $signed({sm & v[W-1], v});
    endfunction

    // Booth recode on {Q0,Q-1}; W+1-bit wrap-around is intended.
    function automatic logic signed [W:0] booth_add(input logic signed [W:0] acc,
                                                    input logic signed [W:0] mc,
                                                    input logic [1:0]        pair);
        case (pair)
            2'b10:   return acc - mc;
            2'b01:   return acc + mc;
            default: return acc;
        endcase
    endfunction

    assign accept    = bus.start && (state != RUN);
    assign last_step = (state == RUN) && (count_r == CNT_W'(W));

    // Step datapath: add/sub then arithmetic shift right of {A,Q,Q-1}.
    always_comb begin
        a_step = booth_add(a, m, {q[0], qm1});
        a_shf  = a_step >>> 1;
        q_shf  = {a_step[0], q[W:1]};
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last_step) state_nxt = DONE;
            DONE:    state_nxt = bus.start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath registers; result only moves on the final step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a        <= '0;
            m        <= '0;
            q        <= '0;
            qm1      <= 1'b0;
            result_r <= '0;
            count_r  <= '0;
        end else if (accept) begin
            a        <= '0;
            m        <= extend(bus.input1, bus.signed_mode);
            q        <= extend(bus.input2, bus.signed_mode);
            qm1      <= 1'b0;
            count_r  <= '0;
        end else if (state == RUN) begin
            a        <= a_shf;
            q        <= q_shf;
            qm1      <= q[0];
            count_r  <= count_r + CNT_W'(1);
            if (last_step) begin
                // low 2W bits of the 2(W+1)-bit {A,Q}
                result_r <= {a_shf[W-2:0], q_shf};
            end
        end
    end

    assign bus.busy   = (state == RUN);
    assign bus.done   = (state == DONE);
    assign bus.result = result_r;
    assign bus.count  = count_r;

endmodule

// File: tb/tb_booth_seq_mult.sv
// ---------------------------------------------------------------------------
// tb_booth_seq_mult
// Bench for booth_seq_mult at W=4, 8 and 16. Expected products are queued
// when an operation is started and popped by a per-instance monitor on done.
// ---------------------------------------------------------------------------
module tb_booth_seq_mult;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    booth_seq_mult_if #(.W(4))  if4 ();
    booth_seq_mult_if #(.W(8))  if8 ();
    booth_seq_mult_if #(.W(16)) if16 ();

    booth_seq_mult #(.W(4))  dut4  (.clk(clk), .reset(reset), .bus(if4));
    booth_seq_mult #(.W(8))  dut8  (.clk(clk), .reset(reset), .bus(if8));
    booth_seq_mult #(.W(16)) dut16 (.clk(clk), .reset(reset), .bus(if16));

    logic [31:0] sb4[$];
    logic [31:0] sb8[$];
    logic [31:0] sb16[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference product, masked to 2w bits.
    function automatic logic [31:0] refp(input int w, input bit sm,
                                         input logic [15:0] a, input logic [15:0] b);
        longint x, y, p;
        x = longint'(a) & ((longint'(1) << w) - 1);
        y = longint'(b) & ((longint'(1) << w) - 1);
        if (sm && a[w-1]) x = x - (longint'(1) << w);
        if (sm && b[w-1]) y = y - (longint'(1) << w);
        p = (x * y) & ((longint'(1) << (2 * w)) - 1);
        return p[31:0];
    endfunction

    // Monitors: on each done pop the scoreboard and check result, count and busy length.
    int blen4 = 0, blen8 = 0, blen16 = 0;
    logic [31:0] e4, e8, e16;

    always @(negedge clk) begin
        if (reset) blen4 = 0;
        else begin
            if (if4.busy) blen4++;
            if (if4.done) begin
                if (sb4.size() == 0) chk("w4 done without pending op", 32'(sb4.size()), 1);
                else begin
                    e4 = sb4.pop_front();
                    chk("w4 result", if4.result, e4);
                end
                chk("w4 count", if4.count, 5);
                chk("w4 busy length", blen4, 5);
                blen4 = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (reset) blen8 = 0;
        else begin
            if (if8.busy) blen8++;
            if (if8.done) begin
                if (sb8.size() == 0) chk("w8 done without pending op", 32'(sb8.size()), 1);
                else begin
                    e8 = sb8.pop_front();
                    chk("w8 result", if8.result, e8);
                end
                chk("w8 count", if8.count, 9);
                chk("w8 busy length", blen8, 9);
                blen8 = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (reset) blen16 = 0;
        else begin
            if (if16.busy) blen16++;
            if (if16.done) begin
                if (sb16.size() == 0) chk("w16 done without pending op", 32'(sb16.size()), 1);
                else begin
                    e16 = sb16.pop_front();
                    chk("w16 result", if16.result, e16);
                end
                chk("w16 count", if16.count, 17);
                chk("w16 busy length", blen16, 17);
                blen16 = 0;
            end
        end
    end

    // Bounded wait for done on instance W=which; dc gets the cycle stamp.
    task automatic wait_done(input int which, output int dc);
        logic d;
        dc = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            case (which)
                4:       d = if4.done;
                8:       d = if8.done;
                default: d = if16.done;
            endcase
            if (d) begin
                dc = cyc;
                return;
            end
        end
        chk("done timeout", 0, 1);
    endtask

    // Start one operation from IDLE, wait for it, check latency.
    task automatic mult(input int which, input bit sm, input logic [15:0] a,
                        input logic [15:0] b, input logic [31:0] expv);
        int acc, dc;
        case (which)
            4: begin
                if4.signed_mode = sm; if4.input1 = a[3:0]; if4.input2 = b[3:0];
                if4.start = 1'b1; sb4.push_back(expv);
            end
            8: begin
                if8.signed_mode = sm; if8.input1 = a[7:0]; if8.input2 = b[7:0];
                if8.start = 1'b1; sb8.push_back(expv);
            end
            default: begin
                if16.signed_mode = sm; if16.input1 = a; if16.input2 = b;
                if16.start = 1'b1; sb16.push_back(expv);
            end
        endcase
        @(posedge clk); #1;
        if4.start = 1'b0; if8.start = 1'b0; if16.start = 1'b0;
        acc = cyc;
        wait_done(which, dc);
        chk("latency", 32'(dc - acc), 32'(which + 1));
        @(posedge clk); #1;
    endtask

    int          acc, dc, prev;
    bit          nxs;
    logic [3:0]  nxa, nxb;
    logic [15:0] ra, rb;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        if4.start = 0;  if4.signed_mode = 0;  if4.input1 = 0;  if4.input2 = 0;
        if8.start = 0;  if8.signed_mode = 0;  if8.input1 = 0;  if8.input2 = 0;
        if16.start = 0; if16.signed_mode = 0; if16.input1 = 0; if16.input2 = 0;
        @(posedge clk); #1;
        chk("reset busy",   if4.busy, 0);
        chk("reset done",   if4.done, 0);
        chk("reset result", if4.result, 0);
        chk("reset count",  if4.count, 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        // Signed directed vectors, each from IDLE
        mult(4, 1, 16'h4, 16'h5, 32'h14);
        mult(4, 1, 16'h0, 16'h3, 32'h00);
        mult(4, 1, 16'hE, 16'h7, 32'hF2);
        mult(4, 1, 16'hC, 16'hC, 32'h10);
        // Boundaries
        mult(4, 1, 16'h8, 16'h8, 32'h40);
        mult(4, 0, 16'hF, 16'hF, 32'hE1);
        mult(4, 0, 16'h8, 16'h1, 32'h08);
        mult(4, 1, 16'h8, 16'h7, 32'hC8);

        // Result/count hold through idle cycles with toggling operands
        for (int i = 0; i < 10; i++) begin
            if4.input1 = 4'($urandom); if4.input2 = 4'($urandom);
            if4.signed_mode = ~if4.signed_mode;
            @(negedge clk);
            chk("hold result", if4.result, 8'hC8);
            chk("hold count",  if4.count, 5);
        end
        @(posedge clk); #1;

        // Back-to-back with start held high; disturb inputs inside RUN
        if4.signed_mode = 1; if4.input1 = 4'h3; if4.input2 = 4'hD; if4.start = 1;
        @(posedge clk); #1;
        acc = cyc;
        sb4.push_back(refp(4, 1, 16'h3, 16'hD));
        prev = -1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if4.start = 0; if4.input1 = 4'($urandom); if4.input2 = 4'($urandom);
            if4.signed_mode = ~if4.signed_mode;
            @(posedge clk); #1;
            if4.start = 1; if4.input1 = 4'($urandom);
            nxs = 1'($urandom); nxa = 4'($urandom); nxb = 4'($urandom);
            if4.signed_mode = nxs; if4.input1 = nxa; if4.input2 = nxb;
            wait_done(4, dc);
            chk("btb latency", 32'(dc - acc), 5);
            if (k > 0) chk("btb spacing", 32'(dc - prev), 6);
            prev = dc;
            @(posedge clk); #1;
            acc = cyc;
            sb4.push_back(refp(4, nxs, {12'h0, nxa}, {12'h0, nxb}));
        end
        if4.start = 0;
        wait_done(4, dc);
        chk("btb latency", 32'(dc - acc), 5);
        chk("btb spacing", 32'(dc - prev), 6);
        @(posedge clk); #1;

        // Reset mid-run (between edges at step 3)
        mult(4, 1, 16'h7, 16'h7, 32'h31);
        if4.signed_mode = 1; if4.input1 = 4'h5; if4.input2 = 4'hD; if4.start = 1;
        @(posedge clk); #1;
        if4.start = 0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort busy",   if4.busy, 0);
        chk("abort done",   if4.done, 0);
        chk("abort result", if4.result, 0);
        chk("abort count",  if4.count, 0);
        if4.signed_mode = 0; if4.input1 = 4'h6; if4.input2 = 4'h7; if4.start = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("start ignored in reset", if4.busy, 0);
        reset = 1'b0;
        sb4.push_back(32'h2A);
        @(posedge clk); #1;
        if4.start = 0;
        acc = cyc;
        wait_done(4, dc);
        chk("post-reset latency", 32'(dc - acc), 5);
        @(posedge clk); #1;

        // Parameterised runs
        mult(8, 1, 16'h80, 16'h80, 32'h4000);
        mult(8, 0, 16'hFF, 16'hFF, 32'hFE01);
        for (int i = 0; i < 6; i++) begin
            ra = 16'($urandom); rb = 16'($urandom);
            mult(8, 1'(i), ra, rb, refp(8, 1'(i), ra, rb));
        end
        mult(16, 1, 16'h8000, 16'h8000, 32'h4000_0000);
        mult(16, 0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001);
        for (int i = 0; i < 6; i++) begin
            ra = 16'($urandom); rb = 16'($urandom);
            mult(16, 1'(i), ra, rb, refp(16, 1'(i), ra, rb));
        end

        repeat (3) @(posedge clk);
        chk("sb4 drained",  32'(sb4.size()), 0);
        chk("sb8 drained",  32'(sb8.size()), 0);
        chk("sb16 drained", 32'(sb16.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/booth_seq_mult.md
BOOTH_SEQ_MULT -- requirements
Module: booth_seq_mult

Interface
REQ-001 Parameter W, default 4, operand width in bits; legal range W >= 2.
REQ-002 Parameter CNT_W, default $clog2(W+2), width of the count output.
REQ-003 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port start  input  1  request to begin a multiply; honoured only when busy is low.
REQ-006 Port signed_mode  input  1  1 = two's-complement operands, 0 = unsigned operands; sampled with the operands.
REQ-007 Port input1  input  W  multiplicand.
REQ-008 Port input2  input  W  multiplier.
REQ-009 Port busy  output  1  high while an operation is in progress.
REQ-010 Port done  output  1  single-cycle pulse marking a valid result.
REQ-011 Port result  output  2W  product; signed in signed mode, unsigned otherwise.
REQ-012 Port count  output  CNT_W  number of Booth steps completed in the current or last operation.

Function
REQ-013 The FSM SHALL have three states: IDLE, RUN and DONE; busy = (state == RUN); done = (state == DONE).
REQ-014 Accept edge E0: start = 1 while busy = 0 (in IDLE or DONE).
- Operands and signed_mode are captured at E0.
- Operand extension: sign-extended to W+1 bits in signed mode, zero-extended in unsigned mode.
- Initialisation: A = 0, Q = extended input2, Q-1 = 0, M = extended input1.
- count = 0; state moves to RUN.
REQ-015 The block SHALL perform one radix-2 Booth step on each of edges E1..E(W+1).
- Q0,Q-1 = 10: A = A - M.
- Q0,Q-1 = 01: A = A + M.
- Q0,Q-1 = 00 or 11: A unchanged.
- Each step is followed by an arithmetic right shift of {A,Q,Q-1}.
- count increments by 1 per step.
REQ-016 Arithmetic on A SHALL use W+1 bits with wrap-around (no overflow flag).
- result = low 2W bits of the 2(W+1)-bit {A,Q}.
- This is exact for every operand pair in both modes.
REQ-017 At edge E(W+1) the FSM SHALL enter DONE, load result and leave count = W+1.
- busy is high for exactly W+1 cycles; done is high for exactly 1 cycle.
- Latency from E0 to done is W+1 edges.
REQ-018 result and count SHALL be held unchanged from DONE until the next accept edge.
REQ-019 In DONE, start = 1 SHALL be accepted (back-to-back operation, no IDLE cycle); otherwise the FSM moves to IDLE.
REQ-020 start during RUN SHALL be ignored.
- Operand and signed_mode changes during RUN SHALL have no effect.
- No request is queued.
REQ-021 result SHALL change only at the E(W+1) edge or on reset, never during RUN.
REQ-022 Outputs SHALL be registered (no combinational path from inputs to outputs).

Reset
REQ-023 Asserting reset SHALL, without waiting for a clock edge:
- force state = IDLE;
- drive busy = 0, done = 0, result = 0, count = 0;
- clear A, Q, Q-1 and M.
REQ-024 Reset asserted during RUN or DONE SHALL abort the operation; no done pulse SHALL follow until a new start is accepted.
REQ-025 While reset is high, start SHALL be ignored.
- A start sampled high at the first rising edge after reset deasserts SHALL be accepted normally.

Verification
REQ-026 W=4, signed: (4,5), then (0,3), then (-2,7), then (-4,-4), each started from IDLE.
- Results 8'h14, 8'h00, 8'hF2, 8'h10.
- done occurs 5 edges after each accept; count = 5 at done.
REQ-027 W=4 boundaries:
- signed (-8,-8) -> 8'h40; signed (-8,7) -> 8'hC8.
- unsigned (15,15) -> 8'hE1; unsigned (8,1) -> 8'h08.
REQ-028 Start held high continuously, W=4:
- accept in DONE gives back-to-back operations with done every 6 cycles;
- start pulses and operand changes inside RUN do not alter the result in progress.
REQ-029 Reset asserted between clock edges at step 3 of a running multiply:
- outputs go to 0 immediately; no done pulse follows;
- a fresh start after reset produces the correct product.
REQ-030 Parameterised run, W=8 and W=16: random signed and unsigned operands.
- result matches the reference product; busy is high for W+1 cycles; count width = $clog2(W+2).
REQ-031 After done: result and count stay stable through at least 10 idle cycles with input1/input2 toggling.
